// File: rtl/ripple_pkg.sv
// Shared constants and helpers for the ripple-carry adder slice.
// Latency: n/a (compile-time definitions only).
// Backpressure: n/a.
package ripple_pkg;

    // Default operand width used when the adder is instantiated without overrides.
    localparam int RCA_WIDTH = 4;

    // Legal operand width range for the adder.
    localparam int RCA_WIDTH_MIN = 2;
    localparam int RCA_WIDTH_MAX = 32;

    // Three-input majority: the carry function of a single full-adder stage.
    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    // Three-input parity: the sum function of a single full-adder stage.
    function automatic logic xor3(input logic x, input logic y, input logic z);
        return x ^ y ^ z;
    endfunction

endpackage : ripple_pkg

// File: rtl/full_adder.sv
// Single ripple stage: sum = a^b^cin, carry = majority(a,b,cin).
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs continuously.
module full_adder
    import ripple_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = xor3(a, b, cin);
    assign cout = maj3(a, b, cin);

endmodule : full_adder

// File: rtl/ripple_carry_adder.sv
// WIDTH-bit ripple-carry adder with per-stage carry vector and signed overflow.
// Latency: one cycle from in_valid to out_valid; all outputs are registered.
// Backpressure: none; accepts a new operand pair every cycle.
module ripple_carry_adder
    import ripple_pkg::*;
#(
    parameter int WIDTH = RCA_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic [WIDTH-1:0] Cout,
    output logic             ovf,
    output logic             out_valid
);

    // carry_chain[i] is the carry into stage i; carry_chain[WIDTH] is the final carry.
    logic [WIDTH:0]   carry_chain;
    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] cout_d;
    logic             ovf_d;

    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] cout_q;
    logic             ovf_q;
    logic             vld_q;

    assign carry_chain[0] = Cin;

    // True ripple: each stage waits on the previous stage's carry, no lookahead.
    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        full_adder u_fa (
            .a    (A[i]),
            .b    (B[i]),
            .cin  (carry_chain[i]),
            .s    (sum_d[i]),
            .cout (carry_chain[i+1])
        );
    end

    // Per-stage carry-out vector and two's-complement overflow from the top two carries.
    always_comb begin
        cout_d = carry_chain[WIDTH:1];
        ovf_d  = carry_chain[WIDTH] ^ carry_chain[WIDTH-1];
    end

    // Result register: reset wins over in_valid; idle cycles hold data and drop valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= '0;
            ovf_q  <= 1'b0;
            vld_q  <= 1'b0;
        end else begin
            vld_q <= in_valid;
            if (in_valid) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
                ovf_q  <= ovf_d;
            end
        end
    end

    assign S         = sum_q;
    assign Cout      = cout_q;
    assign ovf       = ovf_q;
    assign out_valid = vld_q;

endmodule : ripple_carry_adder

// File: tb/tb_ripple_carry_adder.sv
// Self-checking bench for ripple_carry_adder at WIDTH=4.
// Latency: expects results one cycle after each accepted operand pair.
// Backpressure: none exercised; inputs may be valid every cycle.
module tb_ripple_carry_adder;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Cin;
    logic [W-1:0] S;
    logic [W-1:0] Cout;
    logic         ovf;
    logic         out_valid;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: what the outputs should show after the most recent edge.
    logic [W-1:0] m_s;
    logic [W-1:0] m_c;
    logic         m_ovf;
    logic         m_vld;

    always #5 clk = ~clk;

    ripple_carry_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .S         (S),
        .Cout      (Cout),
        .ovf       (ovf),
        .out_valid (out_valid)
    );

    // Arithmetic reference: carries derived from partial sums of the low bits,
    // overflow from the signed sum falling outside the representable range.
    function automatic void ref_add(input int a, input int b, input int cin,
                                    output logic [W-1:0] s, output logic [W-1:0] c,
                                    output logic o);
        int total, part, mask, sa, sb, r;
        total = a + b + cin;
        s = W'(total);
        for (int i = 0; i < W; i++) begin
            mask = (1 << (i + 1)) - 1;
            part = (a & mask) + (b & mask) + cin;
            c[i] = ((part >> (i + 1)) & 1) != 0;
        end
        sa = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
        sb = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
        r  = sa + sb + cin;
        o  = (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
    endfunction

    // Drive one cycle of inputs at the falling edge, advance the model at the
    // rising edge, and return at the next falling edge ready for sampling.
    task automatic cycle(input logic rst, input logic v, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic ci);
        rst_n    = rst;
        in_valid = v;
        A        = a;
        B        = b;
        Cin      = ci;
        @(posedge clk);
        if (!rst) begin
            m_s = '0; m_c = '0; m_ovf = 1'b0; m_vld = 1'b0;
        end else if (v) begin
            ref_add(int'(a), int'(b), int'(ci), m_s, m_c, m_ovf);
            m_vld = 1'b1;
        end else begin
            m_vld = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            cycle(1'b0, 1'b1, W'($urandom), W'($urandom), 1'($urandom));
            n_checks++;
            if ({out_valid, ovf, Cout, S} !== '0) begin
                n_fail++;
                $display("FAIL reset[%0d]: got v=%b ovf=%b cout=%b s=%b, want all zero",
                         k, out_valid, ovf, Cout, S);
            end
        end
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic [W-1:0] s;
        logic [W-1:0] c;
        logic         o;
        int           sum;
    } vec_t;

    task automatic test_directed();
        vec_t tbl[5];
        tbl[0] = '{4'b0001, 4'b0000, 1'b0, 4'b0001, 4'b0000, 1'b0, 1};
        tbl[1] = '{4'b0010, 4'b0100, 1'b1, 4'b0111, 4'b0000, 1'b0, 7};
        tbl[2] = '{4'b1011, 4'b0110, 1'b0, 4'b0001, 4'b1110, 1'b0, 17};
        tbl[3] = '{4'b0101, 4'b0011, 1'b1, 4'b1001, 4'b0111, 1'b1, 9};
        tbl[4] = '{4'b1111, 4'b1111, 1'b1, 4'b1111, 4'b1111, 1'b0, 31};
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, 1'b1, tbl[k].a, tbl[k].b, tbl[k].ci);
            n_checks++;
            if ({out_valid, ovf, Cout, S} !== {1'b1, tbl[k].o, tbl[k].c, tbl[k].s}) begin
                n_fail++;
                $display("FAIL directed[%0d]: got v=%b ovf=%b cout=%b s=%b, want v=1 ovf=%b cout=%b s=%b",
                         k, out_valid, ovf, Cout, S, tbl[k].o, tbl[k].c, tbl[k].s);
            end
            n_checks++;
            if (int'({Cout[W-1], S}) !== tbl[k].sum) begin
                n_fail++;
                $display("FAIL directed_sum[%0d]: got %0d, want %0d",
                         k, int'({Cout[W-1], S}), tbl[k].sum);
            end
        end
    endtask

    // Follows the all-ones case: idle cycles with changing operands must not disturb data.
    task automatic test_hold();
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 1'b0, W'($urandom), W'($urandom), 1'($urandom));
            n_checks++;
            if ({out_valid, ovf, Cout, S} !== {1'b0, 1'b0, 4'b1111, 4'b1111}) begin
                n_fail++;
                $display("FAIL hold[%0d]: got v=%b ovf=%b cout=%b s=%b, want v=0 ovf=0 cout=1111 s=1111",
                         k, out_valid, ovf, Cout, S);
            end
        end
    endtask

    task automatic test_reset_during_valid();
        cycle(1'b1, 1'b1, 4'b0101, 4'b0011, 1'b1);
        cycle(1'b0, 1'b1, 4'b1111, 4'b0001, 1'b0);
        n_checks++;
        if ({out_valid, ovf, Cout, S} !== '0) begin
            n_fail++;
            $display("FAIL reset_with_valid: got v=%b ovf=%b cout=%b s=%b, want all zero",
                     out_valid, ovf, Cout, S);
        end
        cycle(1'b1, 1'b0, 4'b1111, 4'b0001, 1'b0);
        n_checks++;
        if ({out_valid, ovf, Cout, S} !== '0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got v=%b ovf=%b cout=%b s=%b, want all zero",
                     out_valid, ovf, Cout, S);
        end
        cycle(1'b1, 1'b1, 4'b1111, 4'b0001, 1'b0);
        n_checks++;
        if ({out_valid, ovf, Cout, S} !== {1'b1, 1'b0, 4'b1111, 4'b0000}) begin
            n_fail++;
            $display("FAIL first_after_reset: got v=%b ovf=%b cout=%b s=%b, want v=1 ovf=0 cout=1111 s=0000",
                     out_valid, ovf, Cout, S);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 200; k++) begin
            cycle(1'b1, 1'b1, W'($urandom), W'($urandom), 1'($urandom));
            n_checks++;
            if ({out_valid, ovf, Cout, S} !== {m_vld, m_ovf, m_c, m_s}) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: got v=%b ovf=%b cout=%b s=%b, want v=%b ovf=%b cout=%b s=%b",
                         k, out_valid, ovf, Cout, S, m_vld, m_ovf, m_c, m_s);
            end
        end
    endtask

    task automatic test_random_mix();
        logic r, v;
        for (int k = 0; k < 300; k++) begin
            r = ($urandom_range(0, 19) != 0);
            v = ($urandom_range(0, 9) < 7);
            cycle(r, v, W'($urandom), W'($urandom), 1'($urandom));
            n_checks++;
            if ({out_valid, ovf, Cout, S} !== {m_vld, m_ovf, m_c, m_s}) begin
                n_fail++;
                $display("FAIL random_mix[%0d]: got v=%b ovf=%b cout=%b s=%b, want v=%b ovf=%b cout=%b s=%b",
                         k, out_valid, ovf, Cout, S, m_vld, m_ovf, m_c, m_s);
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        A        = '0;
        B        = '0;
        Cin      = 1'b0;
        m_s = '0; m_c = '0; m_ovf = 1'b0; m_vld = 1'b0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_hold();
        test_reset_during_valid();
        test_back_to_back();
        test_random_mix();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_ripple_carry_adder
